// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load-data buffering across stalls, load extraction.
// Define WB_DEBUG_TRACE_EN to add the debug_wb_* trace outputs.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [4:0]  m_rn,
    input  logic        m_write_regfile,
    input  logic        m_load,
    input  logic [2:0]  m_load_type,
    input  logic [1:0]  m_addr_lo,
    input  logic [31:0] m_alu_res,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic        wb_write_regfile,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [4:0]  rn_q;
    logic        wr_q;
    logic        load_q;
    logic [2:0]  load_type_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] alu_res_q;
    logic [31:0] rbuf_q, rbuf_d;
    logic        rbuf_vld_q, rbuf_vld_d;

    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            pc_q        <= 32'h0;
            rn_q        <= 5'd0;
            wr_q        <= 1'b0;
            load_q      <= 1'b0;
            load_type_q <= 3'd0;
            addr_lo_q   <= 2'd0;
            alu_res_q   <= 32'h0;
        end else if (!wb_stall) begin
            valid_q     <= m_valid;
            pc_q        <= m_pc;
            rn_q        <= m_rn;
            wr_q        <= m_write_regfile;
            load_q      <= m_load;
            load_type_q <= m_load_type;
            addr_lo_q   <= m_addr_lo;
            alu_res_q   <= m_alu_res;
        end
    end

    // SRAM data is only valid in the first WB cycle; hold it while stalled.
    // A new instruction entering WB (no stall) always wins over capture.
    always_comb begin
        rbuf_d     = rbuf_q;
        rbuf_vld_d = rbuf_vld_q;
        if (!wb_stall) begin
            rbuf_vld_d = 1'b0;
        end else if (!rbuf_vld_q && valid_q && load_q) begin
            rbuf_d     = data_sram_rdata;
            rbuf_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbuf_q     <= 32'h0;
            rbuf_vld_q <= 1'b0;
        end else begin
            rbuf_q     <= rbuf_d;
            rbuf_vld_q <= rbuf_vld_d;
        end
    end

    assign raw = rbuf_vld_q ? rbuf_q : data_sram_rdata;

    always_comb begin
        byte_sel = raw[7:0];
        unique case (addr_lo_q)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = addr_lo_q[1] ? raw[31:16] : raw[15:0];
        case (load_type_q)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_data = {24'h0, byte_sel};
            3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {16'h0, half_sel};
            default: load_data = raw;
        endcase
    end

    assign wb_valid         = valid_q;
    assign waddr            = rn_q;
    assign wb_reg           = (valid_q && wr_q) ? rn_q : 5'd0;
    assign wb_write_regfile = valid_q && wr_q && (rn_q != 5'd0) && !wb_stall;
    assign wdata            = load_q ? load_data : alu_res_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{wb_write_regfile}};
    assign debug_wb_rf_wnum  = waddr;
    assign debug_wb_rf_wdata = wdata;
`else
    // PC is only observed through the trace port.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_rn;
    logic        m_write_regfile;
    logic        m_load;
    logic [2:0]  m_load_type;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_alu_res;
    logic [31:0] data_sram_rdata;
    logic        wb_stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        wb_write_regfile;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    int vectors = 0;
    int miscompares = 0;

    wb_stage dut (
        .clk              (clk),
        .reset            (reset),
        .m_valid          (m_valid),
        .m_pc             (m_pc),
        .m_rn             (m_rn),
        .m_write_regfile  (m_write_regfile),
        .m_load           (m_load),
        .m_load_type      (m_load_type),
        .m_addr_lo        (m_addr_lo),
        .m_alu_res        (m_alu_res),
        .data_sram_rdata  (data_sram_rdata),
        .wb_stall         (wb_stall),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_write_regfile (wb_write_regfile),
        .waddr            (waddr),
        .wdata            (wdata)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    // Reference extraction from the load rules, using plain shifts and integer arithmetic.
    function automatic logic [31:0] ref_extract(input logic [31:0] r, input int lt, input int a);
        longint v;
        case (lt)
            1, 2: begin
                v = (r >> (8 * a)) % 256;
                if (lt == 1 && v >= 128) v = v - 256;
            end
            3, 4: begin
                v = (a >= 2) ? (r >> 16) : (r % 65536);
                if (lt == 3 && v >= 32768) v = v - 65536;
            end
            default: v = r;
        endcase
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] rn, input logic wr, input logic ld,
                             input logic [2:0] lt, input logic [1:0] a, input logic [31:0] alu);
        m_valid         = v;
        m_pc            = $urandom;
        m_rn            = rn;
        m_write_regfile = wr;
        m_load          = ld;
        m_load_type     = lt;
        m_addr_lo       = a;
        m_alu_res       = alu;
    endtask

    task automatic bubble();
        drive_mem(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wb_stall = 1'b0;
        data_sram_rdata = 32'hA5A5_A5A5;
        bubble();
        #12;
        vectors++;
        if ({wb_valid, wb_write_regfile, waddr, wb_reg, wdata} !== 44'h0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b we=%b wa=%0d reg=%0d wd=%h, want all 0",
                     wb_valid, wb_write_regfile, waddr, wb_reg, wdata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive_mem(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678);
        tick();
        bubble();
        #1;
        vectors++;
        if ({wb_write_regfile, waddr, wdata, wb_reg} !== {1'b1, 5'd5, 32'h1234_5678, 5'd5}) begin
            miscompares++;
            $display("FAIL alu_write: got we=%b wa=%0d wd=%h reg=%0d, want 1 5 12345678 5",
                     wb_write_regfile, waddr, wdata, wb_reg);
        end
        tick();
        vectors++;
        if (wb_write_regfile !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_single_pulse: got we=%b, want 0", wb_write_regfile);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lts [6] = '{3'b001, 3'b010, 3'b001, 3'b011, 3'b100, 3'b000};
        logic [1:0]  as  [6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            drive_mem(1'b1, 5'd9, 1'b1, 1'b1, lts[i], as[i], 32'hCAFE_0000);
            data_sram_rdata = $urandom;
            tick();
            bubble();
            data_sram_rdata = 32'h80FF_7F01;
            #1;
            vectors++;
            if (wdata !== exp[i] || wb_write_regfile !== 1'b1) begin
                miscompares++;
                $display("FAIL load_extract[%0d]: got wd=%h we=%b, want wd=%h we=1",
                         i, wdata, wb_write_regfile, exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_stall();
        int pulses = 0;
        drive_mem(1'b1, 5'd7, 1'b1, 1'b1, 3'b000, 2'd0, 32'h0);
        tick();
        bubble();
        data_sram_rdata = 32'hDEAD_BEEF;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wb_write_regfile) pulses++;
            vectors++;
            if (wb_reg !== 5'd7) begin
                miscompares++;
                $display("FAIL stall_wb_reg[%0d]: got %0d, want 7", i, wb_reg);
            end
            tick();
            data_sram_rdata = 32'h0;
        end
        wb_stall = 1'b0;
        #1;
        vectors++;
        if (wdata !== 32'hDEAD_BEEF || wb_write_regfile !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: got wd=%h we=%b, want deadbeef 1", wdata, wb_write_regfile);
        end
        if (wb_write_regfile) pulses++;
        tick();
        if (wb_write_regfile) pulses++;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL stall_pulse_count: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_rn0();
        drive_mem(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h5555_AAAA);
        tick();
        bubble();
        #1;
        vectors++;
        if (wb_write_regfile !== 1'b0 || wb_reg !== 5'd0 || wb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rn0: got we=%b reg=%0d v=%b, want 0 0 1",
                     wb_write_regfile, wb_reg, wb_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_mem(1'b1, 5'd12, 1'b1, 1'b1, 3'b000, 2'd0, 32'h7777_7777);
        tick();
        bubble();
        data_sram_rdata = 32'h1357_9BDF;
        wb_stall = 1'b1;
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({wb_valid, wb_write_regfile, waddr, wb_reg, wdata} !== 44'h0) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got v=%b we=%b wa=%0d reg=%0d wd=%h, want all 0",
                     wb_valid, wb_write_regfile, waddr, wb_reg, wdata);
        end
        #1;
        reset = 1'b1;
        wb_stall = 1'b0;
        tick();
        #1;
        vectors++;
        if (wb_write_regfile !== 1'b0 || wb_valid !== 1'b0 || wb_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL post_reset_bubble: got we=%b v=%b reg=%0d, want 0 0 0",
                     wb_write_regfile, wb_valid, wb_reg);
        end
    endtask

    task automatic test_back_to_back();
        drive_mem(1'b1, 5'd3, 1'b1, 1'b1, 3'b000, 2'd0, 32'h0);
        tick();
        drive_mem(1'b1, 5'd4, 1'b1, 1'b1, 3'b000, 2'd0, 32'h0);
        data_sram_rdata = 32'h0000_0333;
        #1;
        vectors++;
        if ({wb_write_regfile, waddr, wdata} !== {1'b1, 5'd3, 32'h0000_0333}) begin
            miscompares++;
            $display("FAIL b2b_first: got we=%b wa=%0d wd=%h, want 1 3 00000333",
                     wb_write_regfile, waddr, wdata);
        end
        tick();
        bubble();
        data_sram_rdata = 32'h0000_0444;
        #1;
        vectors++;
        if ({wb_write_regfile, waddr, wdata} !== {1'b1, 5'd4, 32'h0000_0444}) begin
            miscompares++;
            $display("FAIL b2b_second: got we=%b wa=%0d wd=%h, want 1 4 00000444",
                     wb_write_regfile, waddr, wdata);
        end
        tick();
    endtask

    // Model tracks the WB instruction and the SRAM word seen in its first WB cycle.
    task automatic test_random();
        logic        mv = 1'b0, mwr = 1'b0, mld = 1'b0, first = 1'b0;
        logic [4:0]  mrn = 5'd0;
        logic [2:0]  mlt = 3'd0;
        logic [1:0]  ma = 2'd0;
        logic [31:0] malu = 32'h0, saved = 32'h0, raw, exp_wd;
        logic [4:0]  exp_reg;
        logic        exp_we;
        reset = 1'b0;
        wb_stall = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        for (int c = 0; c < 400; c++) begin
            drive_mem($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), 1'($urandom),
                      3'($urandom), 2'($urandom), $urandom);
            data_sram_rdata = $urandom;
            wb_stall = ($urandom_range(0, 2) == 0);
            #1;
            raw     = first ? data_sram_rdata : saved;
            exp_wd  = mld ? ref_extract(raw, int'(mlt), int'(ma)) : malu;
            exp_reg = (mv && mwr) ? mrn : 5'd0;
            exp_we  = mv && mwr && (mrn != 0) && !wb_stall;
            vectors++;
            if (wb_valid !== mv || wb_reg !== exp_reg || waddr !== mrn || wb_write_regfile !== exp_we
                || (mv && wdata !== exp_wd)) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%b reg=%0d wa=%0d we=%b wd=%h, want %b %0d %0d %b %h",
                         c, wb_valid, wb_reg, waddr, wb_write_regfile, wdata,
                         mv, exp_reg, mrn, exp_we, exp_wd);
            end
            @(posedge clk);
            if (!wb_stall) begin
                mv = m_valid; mrn = m_rn; mwr = m_write_regfile; mld = m_load;
                mlt = m_load_type; ma = m_addr_lo; malu = m_alu_res;
                first = 1'b1;
            end else if (first) begin
                saved = data_sram_rdata;
                first = 1'b0;
            end
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stall();
        test_rn0();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
